// File: rtl/ritc_pkg.sv
// ----------------------------------------------------------------------------
// ritc_pkg
// Shared definitions for the RITC lane aligner:
//   - ritc_state_t : alignment FSM state encoding
//   - DEF_*        : default parameter values for the aligner
//   - idx_width()  : width of an index covering 0..n-1 (never 0 bits)
//   - cnt_width()  : width of a counter that must reach max_val inclusive
// ----------------------------------------------------------------------------
package ritc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_SLIP   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } ritc_state_t;

    localparam int DEF_NLANES        = 12;
    localparam int DEF_DESER         = 4;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_VERIFY_CYCLES = 256;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/ritc_lane_cmp.sv
// ----------------------------------------------------------------------------
// ritc_lane_cmp
// Registers the deserialized channel word once, selects the nibble of the
// lane currently being aligned and compares it with the training pattern.
//   SYSCLK    in  : clock
//   rst_i     in  : asynchronous active-high reset
//   dat_i     in  : NLANES*DESER channel word, lane k at [DESER*k +: DESER]
//   lane_i    in  : lane index to compare
//   pattern_i in  : captured training pattern
//   match_o   out : registered lane nibble equals pattern (combinational
//                   from the registered word, so one cycle after dat_i)
// ----------------------------------------------------------------------------
module ritc_lane_cmp
    import ritc_pkg::*;
#(
    parameter int NLANES = DEF_NLANES,
    parameter int DESER  = DEF_DESER,
    parameter int LANE_W = idx_width(DEF_NLANES)
) (
    input  logic                      SYSCLK,
    input  logic                      rst_i,
    input  logic [NLANES*DESER-1:0]   dat_i,
    input  logic [LANE_W-1:0]         lane_i,
    input  logic [DESER-1:0]          pattern_i,
    output logic                      match_o
);

    logic [NLANES*DESER-1:0] dat_reg;
    logic [DESER-1:0]        lane_nib [NLANES];

    always_ff @(posedge SYSCLK or posedge rst_i) begin
        if (rst_i) begin
            dat_reg <= '0;
        end else begin
            dat_reg <= dat_i;
        end
    end

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane_nib
            assign lane_nib[gi] = dat_reg[gi*DESER +: DESER];
        end
    endgenerate

    assign match_o = (lane_nib[lane_i] == pattern_i);

endmodule

// File: rtl/ritc_lane_aligner.sv
// ----------------------------------------------------------------------------
// ritc_lane_aligner
// Per-lane bitslip training for one RITC channel. Lanes are visited in order
// 0..NLANES-1; each lane settles, is checked against the training pattern,
// then must match for VERIFY_CYCLES consecutive words to lock. A mismatch
// requests one bitslip; after DESER slips without locking the lane is failed.
//   SYSCLK        in  : clock
//   rst_i         in  : asynchronous active-high reset
//   start_i       in  : pulse to begin a pass (ignored while busy)
//   pattern_i     in  : expected training nibble, captured at start
//   dat_i         in  : deserialized channel word
//   bitslip_o     out : one-cycle bitslip request for the active lane
//   busy_o        out : pass in progress
//   done_o        out : pass finished, held until the next start
//   lane_locked_o out : lanes aligned and verified
//   lane_fail_o   out : lanes that ran out of slip positions
//   err_cnt_o     out : saturating count of mismatches while verifying
// ----------------------------------------------------------------------------
module ritc_lane_aligner
    import ritc_pkg::*;
#(
    parameter int NLANES        = DEF_NLANES,
    parameter int DESER         = DEF_DESER,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int VERIFY_CYCLES = DEF_VERIFY_CYCLES
) (
    input  logic                      SYSCLK,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [DESER-1:0]          pattern_i,
    input  logic [NLANES*DESER-1:0]   dat_i,
    output logic [NLANES-1:0]         bitslip_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [NLANES-1:0]         lane_locked_o,
    output logic [NLANES-1:0]         lane_fail_o,
    output logic [15:0]               err_cnt_o
);

    localparam int LANE_W   = idx_width(NLANES);
    localparam int SLIP_W   = cnt_width(DESER);
    localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
    localparam int VERIFY_W = cnt_width(VERIFY_CYCLES);

    localparam logic [LANE_W-1:0]   LAST_LANE   = LANE_W'(NLANES - 1);
    localparam logic [SLIP_W-1:0]   SLIP_LAST   = SLIP_W'(DESER - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [VERIFY_W-1:0] VERIFY_LAST = VERIFY_W'(VERIFY_CYCLES - 1);

    ritc_state_t          state_reg,      state_next;
    logic [LANE_W-1:0]    lane_reg,       lane_next;
    logic [SLIP_W-1:0]    slip_cnt_reg,   slip_cnt_next;
    logic [SETTLE_W-1:0]  settle_cnt_reg, settle_cnt_next;
    logic [VERIFY_W-1:0]  verify_cnt_reg, verify_cnt_next;
    logic [DESER-1:0]     pattern_reg,    pattern_next;
    logic [NLANES-1:0]    locked_reg,     locked_next;
    logic [NLANES-1:0]    fail_reg,       fail_next;
    logic [15:0]          err_cnt_reg,    err_cnt_next;

    logic                 lane_match;

    ritc_lane_cmp #(
        .NLANES (NLANES),
        .DESER  (DESER),
        .LANE_W (LANE_W)
    ) u_lane_cmp (
        .SYSCLK    (SYSCLK),
        .rst_i     (rst_i),
        .dat_i     (dat_i),
        .lane_i    (lane_reg),
        .pattern_i (pattern_reg),
        .match_o   (lane_match)
    );

    always_ff @(posedge SYSCLK or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            lane_reg       <= '0;
            slip_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            verify_cnt_reg <= '0;
            pattern_reg    <= '0;
            locked_reg     <= '0;
            fail_reg       <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            lane_reg       <= lane_next;
            slip_cnt_reg   <= slip_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            verify_cnt_reg <= verify_cnt_next;
            pattern_reg    <= pattern_next;
            locked_reg     <= locked_next;
            fail_reg       <= fail_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lane_next       = lane_reg;
        slip_cnt_next   = slip_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        verify_cnt_next = verify_cnt_reg;
        pattern_next    = pattern_reg;
        locked_next     = locked_reg;
        fail_next       = fail_reg;
        err_cnt_next    = err_cnt_reg;
        bitslip_o       = '0;
        busy_o          = 1'b1;
        done_o          = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                busy_o = 1'b0;
                done_o = (state_reg == ST_DONE);
                if (start_i) begin
                    state_next      = ST_SETTLE;
                    lane_next       = '0;
                    slip_cnt_next   = '0;
                    settle_cnt_next = '0;
                    verify_cnt_next = '0;
                    pattern_next    = pattern_i;
                    locked_next     = '0;
                    fail_next       = '0;
                    err_cnt_next    = '0;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    settle_cnt_next = '0;
                    state_next      = ST_CHECK;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end

            ST_CHECK: begin
                if (lane_match) begin
                    verify_cnt_next = '0;
                    state_next      = ST_VERIFY;
                end else begin
                    state_next = ST_SLIP;
                end
            end

            ST_VERIFY: begin
                if (lane_match) begin
                    // Last of VERIFY_CYCLES consecutive matches locks the lane.
                    if (verify_cnt_reg == VERIFY_LAST) begin
                        locked_next[lane_reg] = 1'b1;
                        state_next            = ST_NEXT;
                    end else begin
                        verify_cnt_next = verify_cnt_reg + 1'b1;
                    end
                end else begin
                    if (err_cnt_reg != ERR_CNT_MAX) begin
                        err_cnt_next = err_cnt_reg + 16'd1;
                    end
                    state_next = ST_SLIP;
                end
            end

            ST_SLIP: begin
                // SLIP is always left after one cycle and is never re-entered
                // directly, so pulses stay one-hot and non-consecutive.
                bitslip_o[lane_reg] = 1'b1;
                slip_cnt_next       = slip_cnt_reg + 1'b1;
                if (slip_cnt_reg == SLIP_LAST) begin
                    fail_next[lane_reg] = 1'b1;
                    state_next          = ST_NEXT;
                end else begin
                    settle_cnt_next = '0;
                    state_next      = ST_SETTLE;
                end
            end

            ST_NEXT: begin
                slip_cnt_next = '0;
                if (lane_reg == LAST_LANE) begin
                    state_next = ST_DONE;
                end else begin
                    lane_next       = lane_reg + 1'b1;
                    settle_cnt_next = '0;
                    state_next      = ST_SETTLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign lane_locked_o = locked_reg;
    assign lane_fail_o   = fail_reg;
    assign err_cnt_o     = err_cnt_reg;

endmodule

// File: tb/tb_ritc_lane_aligner.sv
// ----------------------------------------------------------------------------
// tb_ritc_lane_aligner
// Drives ritc_lane_aligner with a channel model: every lane carries the
// training pattern rotated left by a per-lane offset (or stuck at zero), and
// each bitslip pulse on a lane rotates that lane back by one bit. Expected
// slip counts, lock/fail masks and pass length come from the configuration.
// ----------------------------------------------------------------------------
module tb_ritc_lane_aligner;

    localparam int NL     = 12;
    localparam int DS     = 4;
    localparam int SETTLE = 16;
    localparam int VERIFY = 256;
    // One lane without slips: settle, one check word, verify words, next.
    localparam int LANE_T = SETTLE + 1 + VERIFY + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [DS-1:0]  pattern;
    logic [NL*DS-1:0] dat;
    logic [NL-1:0]  bitslip_o;
    logic           busy_o;
    logic           done_o;
    logic [NL-1:0]  lane_locked_o;
    logic [NL-1:0]  lane_fail_o;
    logic [15:0]    err_cnt_o;

    always #5 clk = ~clk;

    ritc_lane_aligner #(
        .NLANES        (NL),
        .DESER         (DS),
        .SETTLE_CYCLES (SETTLE),
        .VERIFY_CYCLES (VERIFY)
    ) dut (
        .SYSCLK        (clk),
        .rst_i         (rst),
        .start_i       (start),
        .pattern_i     (pattern),
        .dat_i         (dat),
        .bitslip_o     (bitslip_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .lane_locked_o (lane_locked_o),
        .lane_fail_o   (lane_fail_o),
        .err_cnt_o     (err_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Channel configuration (written by the stimulus block only).
    logic [DS-1:0] tx_pattern;
    int            cfg_rot   [NL];
    bit            cfg_stuck [NL];
    bit            cfg_hold  [NL];   // lane re-centres itself after a slip
    bit            glitch;
    int            slip_base [NL];

    // Slip monitor state (written by the monitor block only).
    int slip_total [NL] = '{default: 0};
    int slip_viol = 0;
    bit prev_slip = 1'b0;

    always @(negedge clk) begin
        if (bitslip_o != '0) begin
            if ($countones(bitslip_o) != 1 || prev_slip) begin
                slip_viol <= slip_viol + 1;
            end
            for (int k = 0; k < NL; k++) begin
                if (bitslip_o[k]) slip_total[k] <= slip_total[k] + 1;
            end
        end
        prev_slip <= (bitslip_o != '0);
    end

    function automatic logic [DS-1:0] rotl(input logic [DS-1:0] v, input int r);
        logic [DS-1:0] o;
        o = '0;
        for (int i = 0; i < DS; i++) o[(i + r) % DS] = v[i];
        return o;
    endfunction

    int            rot_tmp;
    logic [DS-1:0] nib_tmp;

    always_comb begin
        dat     = '0;
        rot_tmp = 0;
        nib_tmp = '0;
        for (int k = 0; k < NL; k++) begin
            if (cfg_hold[k]) rot_tmp = cfg_rot[k];
            else rot_tmp = (((cfg_rot[k] - (slip_total[k] - slip_base[k])) % DS) + DS) % DS;
            nib_tmp = cfg_stuck[k] ? '0 : rotl(tx_pattern, rot_tmp);
            if (glitch && k == 0) nib_tmp = ~nib_tmp;
            dat[k*DS +: DS] = nib_tmp;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_pass(input logic [DS-1:0] p);
        for (int k = 0; k < NL; k++) slip_base[k] = slip_total[k];
        pattern = p;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done_o && cycles < budget) begin
            tick(1);
            cycles++;
        end
        chk("done_within_budget", {31'd0, done_o}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_bitslip"}, {20'd0, bitslip_o},     32'd0);
        chk({tag, "_busy"},    {31'd0, busy_o},        32'd0);
        chk({tag, "_done"},    {31'd0, done_o},        32'd0);
        chk({tag, "_locked"},  {20'd0, lane_locked_o}, 32'd0);
        chk({tag, "_fail"},    {20'd0, lane_fail_o},   32'd0);
        chk({tag, "_err"},     {16'd0, err_cnt_o},     32'd0);
    endtask

    // Reference: a lane rotated by r needs r slips to realign; a stuck lane
    // burns all DS slip positions and fails. extra0 adds slips on lane 0
    // caused by verify-time corruption.
    task automatic check_pass(input string name, input int exp_err, input int extra0);
        logic [NL-1:0] exp_locked, exp_fail, slip_ok;
        int exp_slips, got_slips, got_total, exp_total;
        exp_locked = '0; exp_fail = '0; slip_ok = '0;
        exp_total = 0; got_total = 0;
        for (int k = 0; k < NL; k++) begin
            exp_slips = cfg_stuck[k] ? DS : cfg_rot[k];
            if (k == 0) exp_slips += extra0;
            got_slips = slip_total[k] - slip_base[k];
            exp_total += exp_slips;
            got_total += got_slips;
            slip_ok[k] = (got_slips == exp_slips);
            if (cfg_stuck[k]) exp_fail[k] = 1'b1;
            else exp_locked[k] = 1'b1;
        end
        chk({name, "_locked"},   {20'd0, lane_locked_o}, {20'd0, exp_locked});
        chk({name, "_fail"},     {20'd0, lane_fail_o},   {20'd0, exp_fail});
        chk({name, "_err"},      {16'd0, err_cnt_o},     exp_err);
        chk({name, "_slip_lanes"}, {20'd0, slip_ok},     {20'd0, {NL{1'b1}}});
        chk({name, "_slip_total"}, got_total,            exp_total);
        chk({name, "_slip_shape"}, slip_viol,            32'd0);
        chk({name, "_busy"},     {31'd0, busy_o},        32'd0);
        $display("pass %-10s pattern=%h locked=%h fail=%h err=%0d slips=%0d",
                 name, tx_pattern, lane_locked_o, lane_fail_o, err_cnt_o, got_total);
    endtask

    function automatic logic [DS-1:0] rand_aperiodic();
        logic [DS-1:0] p;
        do p = DS'($urandom_range(1, 14)); while (p == 4'h5 || p == 4'hA);
        return p;
    endfunction

    task automatic clear_cfg();
        for (int k = 0; k < NL; k++) begin
            cfg_rot[k] = 0; cfg_stuck[k] = 1'b0; cfg_hold[k] = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        int stuck_lane;
        logic [DS-1:0] alt;

        rst = 1'b1; start = 1'b0; pattern = '0; glitch = 1'b0;
        tx_pattern = 4'hA;
        clear_cfg();
        for (int k = 0; k < NL; k++) slip_base[k] = 0;

        // Reset state.
        tick(3);
        check_outputs_zero("reset");

        // All lanes aligned; start in the first cycle after reset release.
        rst = 1'b0;
        start_pass(4'hA);
        chk("aligned_busy", {31'd0, busy_o}, 32'd1);
        wait_done(6000, cyc);
        chk("aligned_cycles", cyc, NL * LANE_T);
        chk("aligned_done", {31'd0, done_o}, 32'd1);
        check_pass("aligned", 0, 0);
        tick(20);
        chk("done_held", {31'd0, done_o}, 32'd1);

        // Lane 5 rotated by 2 (non-periodic pattern so rotations are distinct).
        tx_pattern = 4'b0011;
        cfg_rot[5] = 2;
        start_pass(tx_pattern);
        wait_done(6000, cyc);
        chk("rot5_slips", slip_total[5] - slip_base[5], 32'd2);
        check_pass("rot5", 0, 0);

        // Lane 3 stuck at zero.
        clear_cfg();
        tx_pattern = rand_aperiodic();
        cfg_stuck[3] = 1'b1;
        start_pass(tx_pattern);
        wait_done(6000, cyc);
        chk("stuck3_fail", {20'd0, lane_fail_o}, 32'h008);
        check_pass("stuck3", 0, 0);

        // One corrupted word on lane 0 during verify.
        clear_cfg();
        tx_pattern = rand_aperiodic();
        cfg_hold[0] = 1'b1;
        start_pass(tx_pattern);
        tick(SETTLE + 1 + 100);
        glitch = 1'b1;
        tick(1);
        glitch = 1'b0;
        wait_done(6000, cyc);
        check_pass("glitch0", 1, 1);
        clear_cfg();

        // Asynchronous reset during verify of lane 7.
        tx_pattern = rand_aperiodic();
        start_pass(tx_pattern);
        tick(7 * LANE_T + 100);
        chk("pre_rst_locked", {20'd0, lane_locked_o}, 32'h07F);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        tick(2);
        rst = 1'b0;
        start_pass(tx_pattern);
        wait_done(6000, cyc);
        check_pass("after_rst", 0, 0);

        // Start pulse during settle of lane 2 with a different pattern.
        tx_pattern = rand_aperiodic();
        start_pass(tx_pattern);
        tick(2 * LANE_T + 2);
        chk("settle2_locked", {20'd0, lane_locked_o}, 32'h003);
        alt = ~tx_pattern;
        pattern = alt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(6000, cyc);
        chk("busy_start_cycles", 2 * LANE_T + 2 + 1 + cyc, NL * LANE_T);
        check_pass("busy_start", 0, 0);

        // Randomized offsets, optionally one stuck lane.
        for (int t = 0; t < 3; t++) begin
            clear_cfg();
            tx_pattern = rand_aperiodic();
            for (int k = 0; k < NL; k++) cfg_rot[k] = $urandom_range(0, DS - 1);
            stuck_lane = $urandom_range(0, NL);
            if (stuck_lane < NL) cfg_stuck[stuck_lane] = 1'b1;
            start_pass(tx_pattern);
            wait_done(8000, cyc);
            check_pass("random", 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ritc_lane_aligner.md
RITC_LANE_ALIGNER -- requirements
Module: ritc_lane_aligner

Interface
REQ-001 Parameter NLANES, default 12: bit lanes per RITC channel.
REQ-002 Parameter DESER, default 4: deserialization ratio, i.e. bits per lane per word.
REQ-003 Parameter SETTLE_CYCLES, default 16: wait after start or after a bitslip before any comparison.
REQ-004 Parameter VERIFY_CYCLES, default 256: consecutive matching words required to lock a lane.
REQ-005 SYSCLK  in  1: sole clock; all ports are synchronous to it.
REQ-006 rst_i  in  1: asynchronous, active-high reset.
REQ-007 start_i  in  1: one-cycle pulse that begins an alignment pass.
REQ-008 pattern_i  in  DESER: expected training nibble per lane; sampled at start.
REQ-009 dat_i  in  NLANES*DESER: deserialized channel word; lane k occupies bits [DESER*k+DESER-1 : DESER*k].
REQ-010 bitslip_o  out  NLANES: one-cycle bitslip request per lane.
REQ-011 busy_o  out  1: alignment pass in progress.
REQ-012 done_o  out  1: pass finished; held until the next accepted start.
REQ-013 lane_locked_o  out  NLANES: lane aligned and verified.
REQ-014 lane_fail_o  out  NLANES: lane exhausted all slip positions without locking.
REQ-015 err_cnt_o  out  16: mismatches seen during VERIFY; saturating.

Function
REQ-016 FSM states are IDLE, SETTLE, CHECK, VERIFY, SLIP, NEXT, DONE. Lanes are processed sequentially from 0 to NLANES-1.
REQ-017 IDLE/DONE + start_i -> SETTLE with lane=0. On that transition: pattern_i captured; lane_locked_o, lane_fail_o, err_cnt_o and slip count cleared; done_o deasserted.
REQ-018 start_i while busy_o=1 is ignored.
REQ-019 SETTLE counts SETTLE_CYCLES cycles, then -> CHECK.
REQ-020 CHECK compares one registered word: the current lane nibble versus the captured pattern.
  - Match -> VERIFY, with the verify counter cleared.
  - Mismatch -> SLIP.
REQ-021 VERIFY behaviour:
  - Each matching word increments the verify counter; reaching VERIFY_CYCLES sets lane_locked_o[lane] and goes -> NEXT.
  - Any mismatch increments err_cnt_o (saturating at 0xFFFF) and goes -> SLIP.
REQ-022 SLIP behaviour:
  - Asserts bitslip_o[lane] for exactly one cycle and increments the slip count.
  - If the slip count reaches DESER, set lane_fail_o[lane] and go -> NEXT; otherwise go -> SETTLE.
REQ-023 NEXT clears the slip count.
  - If lane == NLANES-1 -> DONE.
  - Otherwise lane+1 -> SETTLE.
REQ-024 busy_o=1 in every state except IDLE and DONE. done_o=1 only in DONE.
REQ-025 At most one bitslip_o bit is high in any cycle; never two pulses in consecutive cycles.
REQ-026 dat_i is registered once before comparison. Compare latency is 1 cycle from dat_i to the decision.
REQ-027 Lane and slip counters are sized by $clog2. Lane index wraps only through NEXT, never modulo.

Reset
REQ-028 rst_i asserted forces the following, including mid-pass:
  - FSM -> IDLE.
  - All outputs 0: bitslip_o, busy_o, done_o, lane_locked_o, lane_fail_o, err_cnt_o.
  - All counters 0 and the captured pattern 0.
REQ-029 The first cycle after rst_i deasserts accepts start_i.

Structure
REQ-030 FSM state encoding and default parameter constants live in the shared package ritc_pkg.
REQ-031 One sub-module, ritc_lane_cmp: registers the word, muxes the lane nibble by index, outputs a match flag.
REQ-032 No other hierarchy. No IP cores.

Verification
REQ-033 All lanes already aligned, pattern 4'b1010, start.
  - Expected: no bitslip.
  - lane_locked_o=12'hFFF after 12*(16+1+256) cycles plus NEXT/overhead cycles.
  - done_o=1, err_cnt_o=0.
REQ-034 Lane 5 rotated by 2 bits; the model rotates back by one per bitslip_o[5].
  - Expected: exactly 2 pulses on bitslip_o[5]; lane_locked_o=12'hFFF, lane_fail_o=0.
REQ-035 Lane 3 driven constant 4'b0000.
  - Expected: 4 pulses on bitslip_o[3]; lane_fail_o=12'h008, lane_locked_o=12'hFF7.
REQ-036 Single corrupted word injected in lane 0 at verify cycle 100.
  - Expected: err_cnt_o=1, one bitslip, relock after the model realigns.
REQ-037 rst_i asserted during VERIFY of lane 7.
  - Expected: all outputs 0 the same cycle.
  - A new start completes normally.
REQ-038 start_i pulsed during SETTLE of lane 2.
  - Expected: ignored; lane sequence and pattern unchanged.
